// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command handler.
// State encoding, opcode layout and transmit-handshake constants.
package uart_cmd_pkg;

    // FSM encoding kept as plain constants for legacy tools
    localparam int         ST_W        = 3;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EXEC      = 3'd1;
    localparam logic [2:0] S_SEND      = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    // Opcode byte returned for any rejected command
    localparam logic [7:0] ERR_OP = 8'hEE;

    // Register address width carried in the opcode low nibble
    localparam int ADDR_W = 4;

    // Cycles to wait for the controller to report busy after a request
    localparam int BUSY_TIMEOUT = 4;
    localparam int TMO_W        = 3;

    // Opcode byte layout: [7] write, [6:4] reserved, [3:0] address
    typedef struct packed {
        logic              wr;
        logic [2:0]        rsv;
        logic [ADDR_W-1:0] addr;
    } op_t;

    // Saturating 8-bit increment used by both error counters
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_regfile.sv
// Register file behind the UART command port.
// One write port, one combinational read port, flat view of all registers.
module cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DW       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DW-1:0]          wdata,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [DW-1:0]          rdata,
    output logic [NUM_REGS*DW-1:0] regs_flat
);

    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];

    // Next-state of the array: only the addressed entry changes on a write
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs_d[i] = wdata;
                end
            end
        end
    end

    // Combinational read; unmapped addresses return zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == ADDR_W'(i)) begin
                rdata = regs_q[i];
            end
        end
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DW +: DW] = regs_q[g];
    end

endmodule

// File: rtl/uart_cmd_handler.sv
// Turns received UART frames into register reads/writes and replies.
// One-entry input buffer, command FSM, response formation and counters.
module uart_cmd_handler
    import uart_cmd_pkg::*;
#(
    parameter int BYTES    = 2,
    parameter int NUM_REGS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BYTES*8-1:0]           data_received,
    input  logic                         rx_done_tick,
    input  logic                         tx_busy_total,
    output logic [BYTES*8-1:0]           data_to_send,
    output logic                         start_tx,
    output logic [NUM_REGS*(BYTES*8-8)-1:0] regs_flat,
    output logic [7:0]                   ovf_count,
    output logic [7:0]                   err_count
);

    localparam int FW = BYTES * 8;
    localparam int DW = FW - 8;

    logic [ST_W-1:0]  state_q, state_d;
    logic [FW-1:0]    pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [FW-1:0]    cmd_q, cmd_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [FW-1:0]    data_q, data_d;
    logic             start_q, start_d;
    logic [7:0]       ovf_q, ovf_d;
    logic [7:0]       err_q, err_d;

    op_t              op;
    logic [DW-1:0]    payload;
    logic [DW-1:0]    rd_data;
    logic             cmd_ok;
    logic             wr_en;
    logic             consume;

    assign op      = op_t'(cmd_q[FW-1 -: 8]);
    assign payload = cmd_q[DW-1:0];
    assign cmd_ok  = (op.rsv == 3'b000) && (int'(op.addr) < NUM_REGS);
    assign wr_en   = (state_q == S_EXEC) && cmd_ok && op.wr;
    assign consume = (state_q == S_IDLE) && pend_v_q;

    cmd_regfile #(
        .NUM_REGS (NUM_REGS),
        .DW       (DW)
    ) u_regs (
        .clk       (clk),
        .reset     (reset),
        .we        (wr_en),
        .waddr     (op.addr),
        .wdata     (payload),
        .raddr     (op.addr),
        .rdata     (rd_data),
        .regs_flat (regs_flat)
    );

    // Input buffer: accept when empty or being drained this cycle, else drop
    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = ovf_q;
        if (consume) begin
            pend_v_d = 1'b0;
        end
        if (rx_done_tick) begin
            if (!pend_v_q || consume) begin
                pend_d   = data_received;
                pend_v_d = 1'b1;
            end else begin
                ovf_d = sat_inc(ovf_q);
            end
        end
    end

    // Command FSM: take a frame, execute it, request transmit, track busy
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        start_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_v_q) begin
                    cmd_d   = pend_q;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!cmd_ok) begin
                    data_d = {ERR_OP, {DW{1'b0}}};
                    err_d  = sat_inc(err_q);
                end else if (op.wr) begin
                    data_d = {op, payload};
                end else begin
                    data_d = {op, rd_data};
                end
                start_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy_total) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = sat_inc(err_q);
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy_total) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            cmd_q    <= '0;
            tmo_q    <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            ovf_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cmd_q    <= cmd_d;
            tmo_q    <= tmo_d;
            data_q   <= data_d;
            start_q  <= start_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign data_to_send = data_q;
    assign start_tx     = start_q;
    assign ovf_count    = ovf_q;
    assign err_count    = err_q;

endmodule

// File: doc/uart_cmd_handler.md
# uart_cmd_handler

Command-processing stage directly downstream of `uart_controller`. Consumes each deserialized frame (`data_received` qualified by `rx_done_tick`), decodes it as a register read or write against an internal register file, and returns a response frame through the controller's transmit side (`data_to_send`, `start_tx`, `tx_busy_total`). This makes the PC-facing UART link into a small memory-mapped control port for the rest of the FPGA.

## Interface
- `BYTES`, 2, frame size in bytes; frame width `FW = BYTES*8`, payload width `DW = FW-8`; `BYTES >= 2`
- `NUM_REGS`, 8, number of registers (1..16)
- `clk` in 1: system clock (12 MHz)
- `reset` in 1: asynchronous, active-high reset
- `data_received` in FW: frame from `uart_controller`
- `rx_done_tick` in 1: one-cycle strobe; `data_received` is valid in that cycle
- `tx_busy_total` in 1: controller is transmitting a frame
- `data_to_send` out FW: response frame; held stable from `start_tx` until the handler returns to IDLE
- `start_tx` out 1: one-cycle transmit request
- `regs_flat` out NUM_REGS*DW: register file, with reg *i* at bits [i*DW +: DW]
- `ovf_count` out 8: saturating count of dropped frames
- `err_count` out 8: saturating count of rejected commands

## Operation
- Frame decode:
  - opcode byte `op = frame[FW-1:FW-8]`
  - `op[7]` is 1 for write, 0 for read
  - `op[6:4]` are reserved and must be 0
  - `op[3:0]` is the address
  - payload is `frame[DW-1:0]`
- Valid write: `reg[addr] <= payload`; response is `{op, payload}`.
- Valid read: the register file is unchanged; response is `{op, reg[addr]}`.
- Error (reserved bits nonzero, or `addr >= NUM_REGS`): no register change; `err_count` increments; response is `{8'hEE, DW'h0}`.
- Input buffer: one entry (`pend_q`, `pend_v`).
  - `rx_done_tick` with `pend_v=0`: capture the frame.
  - `rx_done_tick` with `pend_v=1` and no consume in that cycle: drop the new frame, increment `ovf_count`.
  - Consume and `rx_done_tick` in the same cycle: the new frame loads and `pend_v` stays 1.
- FSM states and transitions:
  - IDLE: `pend_v` → EXEC (consume).
  - EXEC: decode, perform the write, form the response → SEND.
  - SEND: `start_tx=1` for one cycle → WAIT_BUSY.
  - WAIT_BUSY: `tx_busy_total=1` → WAIT_DONE; after 4 cycles without busy → IDLE (lost-request guard; counts as error).
  - WAIT_DONE: `tx_busy_total=0` → IDLE.
- Frames keep being accepted into the buffer in every state.
- Counters saturate at 8'hFF and never wrap.
- Reset values: all registers 0, `data_to_send=0`, `start_tx=0`, both counters 0, `pend_v=0`, state IDLE.
- Reset asserted mid-transaction aborts immediately; a pending frame is lost. Any byte the controller is already sending is not this block's concern.

## Timing
- `rx_done_tick` at cycle N with `pend_v=0` and FSM in IDLE:
  - `pend_v=1` at N+1
  - EXEC at N+2; a write is visible on `regs_flat` at N+3
  - `start_tx` high at N+3, with `data_to_send` valid the same cycle
- The next frame is not consumed before `tx_busy_total` falls, so transmit requests never overlap.
- A read returns the register value as of the EXEC cycle.
- `regs_flat` is registered and changes only one cycle after a valid write's EXEC.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - FSM state encoding
  - `ERR_OP = 8'hEE`
  - opcode field positions
  - `BUSY_TIMEOUT = 4`
- One natural sub-module, `cmd_regfile`: NUM_REGS×DW registers, one write port, combinational read, flat output.
- Buffer, FSM, decode and counters stay in the top level.

## Test plan
All scenarios use BYTES=2, NUM_REGS=8, and a controller model that raises busy 1 cycle after `start_tx` and holds it for 20 cycles.
- Write frame 16'h8355 → `regs_flat[31:24]=8'h55`; one `start_tx` with `data_to_send=16'h8355`; `err_count=0`.
- After the write, read frame 16'h0300 → `data_to_send=16'h0355`; `regs_flat` unchanged.
- Write frame 16'h8F12 (addr 15 ≥ 8) → response 16'hEE00, `err_count=1`, no register change. Reserved-bit frame 16'hF012 → 16'hEE00, `err_count=2`.
- Three frames 8'h81AA, 8'h82BB, 8'h83CC (as 16'h81AA / 16'h82BB / 16'h83CC) strobed 2 cycles apart → reg1=AA, reg2=BB, reg3 stays 0, `ovf_count=1`, exactly two `start_tx` pulses.
- Controller model never raises busy → FSM returns to IDLE 4 cycles after SEND, `err_count` increments, and the next frame is still processed.
- Assert `reset` during WAIT_DONE with a frame pending → all outputs return to reset values at once; after release, a new write 16'h8177 executes normally.
